alu_issue_stage: RTL and testbench

//  Decode/issue end of the ALU interface: takes a fetched RV64I instruction plus register

---
 rtl/alu_issue_stage_if.sv | 33 +++
 rtl/alu_issue_stage.sv | 170 +++++++++++++++++
 tb/tb_alu_issue_stage.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Handshake/bus bundle between decode (master) and the ALU issue stage (slave).
// Carries the upstream entry, the issued ALU operands and both valid/ready pairs.
interface alu_issue_stage_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_input1;
    logic [XLEN-1:0] out_input2;
    logic [3:0]      out_alu_ctrl;
    logic [XLEN-1:0] out_store;
    logic [XLEN-1:0] out_pc;
    logic [2:0]      out_kind;
    logic            out_br_inv;

    modport master (
        output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        input  in_ready, out_valid, out_input1, out_input2, out_alu_ctrl,
               out_store, out_pc, out_kind, out_br_inv
    );

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        output in_ready, out_valid, out_input1, out_input2, out_alu_ctrl,
               out_store, out_pc, out_kind, out_br_inv
    );
endinterface

// File: rtl/alu_issue_stage.sv
// RV64I decode/issue stage: builds ALU operands and control code, holds them in a
// handshaked ID/EX register backed by a one-entry skid buffer.
module alu_issue_stage #(
    parameter int XLEN = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    alu_issue_stage_if.slave   bus
);
    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_XOR  = 4'b0011;
    localparam logic [3:0] C_SLL  = 4'b0100;
    localparam logic [3:0] C_SRL  = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_SLTU = 4'b1000;
    localparam logic [3:0] C_SRA  = 4'b1101;

    localparam logic [2:0] K_ALU     = 3'd0;
    localparam logic [2:0] K_LOAD    = 3'd1;
    localparam logic [2:0] K_STORE   = 3'd2;
    localparam logic [2:0] K_BRANCH  = 3'd3;
    localparam logic [2:0] K_LUI     = 3'd4;
    localparam logic [2:0] K_ILLEGAL = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [XLEN-1:0] store;
        logic [XLEN-1:0] pc;
        logic [3:0]      ctrl;
        logic [2:0]      kind;
        logic            inv;
    } entry_t;

    function automatic logic [3:0] f3_ctrl(input logic [2:0] f3);
        case (f3)
            3'b000:  f3_ctrl = C_ADD;
            3'b001:  f3_ctrl = C_SLL;
            3'b010:  f3_ctrl = C_SLT;
            3'b011:  f3_ctrl = C_SLTU;
            3'b100:  f3_ctrl = C_XOR;
            3'b101:  f3_ctrl = C_SRL;
            3'b110:  f3_ctrl = C_OR;
            default: f3_ctrl = C_AND;
        endcase
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic            illegal;
    entry_t          dec;

    assign opcode = bus.in_instr[6:0];
    assign f3     = bus.in_instr[14:12];
    assign f7     = bus.in_instr[31:25];
    assign imm_i  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
    assign imm_s  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};

    always_comb begin
        dec      = '0;
        illegal  = 1'b0;
        dec.pc   = bus.in_pc;
        dec.in1  = bus.in_rs1_data;
        dec.ctrl = C_ADD;
        dec.kind = K_ALU;
        case (opcode)
            7'b0110011: begin
                dec.in2 = bus.in_rs2_data;
                if (f7 == 7'b0000000)                     dec.ctrl = f3_ctrl(f3);
                else if (f7 == 7'b0100000 && f3 == 3'b000) dec.ctrl = C_SUB;
                else if (f7 == 7'b0100000 && f3 == 3'b101) dec.ctrl = C_SRA;
                else                                      illegal  = 1'b1;
            end
            7'b0010011: begin
                dec.in2  = imm_i;
                dec.ctrl = f3_ctrl(f3);
                // RV64 shift amount is 6 bits, so funct6 (not funct7) selects the variant
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec.in2 = {{(XLEN-6){1'b0}}, bus.in_instr[25:20]};
                    if (bus.in_instr[31:26] == 6'b010000 && f3 == 3'b101) dec.ctrl = C_SRA;
                    else if (bus.in_instr[31:26] != 6'b000000)              illegal  = 1'b1;
                end
            end
            7'b0000011: begin
                dec.kind = K_LOAD;
                dec.in2  = imm_i;
            end
            7'b0100011: begin
                dec.kind  = K_STORE;
                dec.in2   = imm_s;
                dec.store = bus.in_rs2_data;
            end
            7'b1100011: begin
                dec.kind = K_BRANCH;
                dec.in2  = bus.in_rs2_data;
                case (f3)
                    3'b000:  dec.ctrl = C_SUB;
                    3'b001:  begin dec.ctrl = C_SUB;  dec.inv = 1'b1; end
                    3'b100:  dec.ctrl = C_SLT;
                    3'b101:  begin dec.ctrl = C_SLT;  dec.inv = 1'b1; end
                    3'b110:  dec.ctrl = C_SLTU;
                    3'b111:  begin dec.ctrl = C_SLTU; dec.inv = 1'b1; end
                    default: illegal = 1'b1;
                endcase
            end
            7'b0110111: begin
                dec.kind = K_LUI;
                dec.in1  = '0;
                dec.in2  = {{(XLEN-32){bus.in_instr[31]}}, bus.in_instr[31:12], 12'b0};
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec.in1   = '0;
            dec.in2   = '0;
            dec.store = '0;
            dec.ctrl  = C_AND;
            dec.kind  = K_ILLEGAL;
            dec.inv   = 1'b0;
        end
    end

    entry_t main_q, skid_q;
    logic   main_v, skid_v;
    logic   accept;

    // in_ready is simply "skid empty", which is itself a flop
    assign accept = bus.in_valid && !skid_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!main_v || bus.out_ready) begin
            if (skid_v) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= 1'b0;
            end else begin
                main_v <= accept;
                if (accept) main_q <= dec;
            end
        end else if (accept) begin
            skid_q <= dec;
            skid_v <= 1'b1;
        end
    end

    assign bus.in_ready     = !skid_v;
    assign bus.out_valid    = main_v;
    assign bus.out_input1   = main_q.in1;
    assign bus.out_input2   = main_q.in2;
    assign bus.out_alu_ctrl = main_q.ctrl;
    assign bus.out_store    = main_q.store;
    assign bus.out_pc       = main_q.pc;
    assign bus.out_kind     = main_q.kind;
    assign bus.out_br_inv   = main_q.inv;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: expected entries are queued on acceptance and
// compared field by field whenever the stage hands an entry to EX.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   n_assert = 0;
    int   n_fail   = 0;

    typedef struct {
        logic [63:0] in1;
        logic [63:0] in2;
        logic [63:0] store;
        logic [63:0] pc;
        logic [3:0]  ctrl;
        logic [2:0]  kind;
        logic        inv;
    } exp_t;

    exp_t sb[$];

    alu_issue_stage_if #(.XLEN(64)) bus ();

    alu_issue_stage #(.XLEN(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] in1, input logic [63:0] in2,
                                input logic [3:0] ctrl, input logic [63:0] store,
                                input logic [2:0] kind, input logic inv,
                                input logic [63:0] pc);
        exp_t e;
        e.in1 = in1; e.in2 = in2; e.ctrl = ctrl; e.store = store;
        e.kind = kind; e.inv = inv; e.pc = pc;
        return e;
    endfunction

    // Transfers to EX happen at the next rising edge; sample mid-cycle.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready && !flush) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_out: observed pc %0h expected no entry", bus.out_pc);
            end
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_input1", bus.out_input1, e.in1);
                chk("out_input2", bus.out_input2, e.in2);
                chk("out_alu_ctrl", {60'd0, bus.out_alu_ctrl}, {60'd0, e.ctrl});
                chk("out_store", bus.out_store, e.store);
                chk("out_pc", bus.out_pc, e.pc);
                chk("out_kind", {61'd0, bus.out_kind}, {61'd0, e.kind});
                chk("out_br_inv", {63'd0, bus.out_br_inv}, {63'd0, e.inv});
            end
        end
    end

    task automatic put(input logic [31:0] instr, input logic [63:0] pc,
                       input logic [63:0] rs1, input logic [63:0] rs2);
        bus.in_valid    = 1'b1;
        bus.in_instr    = instr;
        bus.in_pc       = pc;
        bus.in_rs1_data = rs1;
        bus.in_rs2_data = rs2;
    endtask

    task automatic wait_acc(input exp_t e);
        int  n  = 0;
        bit  ok = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (bus.in_ready && !flush) begin
                ok = 1'b1;
                sb.push_back(e);
            end
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        chk("accept_in_time", {63'd0, ok}, 64'd1);
    endtask

    task automatic send(input logic [31:0] instr, input logic [63:0] pc,
                        input logic [63:0] rs1, input logic [63:0] rs2, input exp_t e);
        put(instr, pc, rs1, rs2);
        wait_acc(e);
    endtask

    task automatic drain_all();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_remaining", 64'(sb.size()), 64'd0);
    endtask

    task automatic idle_cycles(input int unsigned k);
        for (int unsigned i = 0; i < k; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_instr    = '0;
        bus.in_pc       = '0;
        bus.in_rs1_data = '0;
        bus.in_rs2_data = '0;
        bus.out_ready   = 1'b0;
        #12;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_input1", bus.out_input1, 64'd0);
        chk("rst_input2", bus.out_input2, 64'd0);
        chk("rst_alu_ctrl", {60'd0, bus.out_alu_ctrl}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // add x3,x1,x2 with latency-1 visibility
        bus.out_ready = 1'b1;
        send(32'h002081B3, 64'h100, 64'd5, 64'd7, mk(64'd5, 64'd7, 4'b0010, 64'd0, 3'd0, 1'b0, 64'h100));
        @(negedge clk);
        chk("add_latency_out_valid", {63'd0, bus.out_valid}, 64'd1);
        drain_all();

        // srai 63, bad-funct6 srai, bge, bne, sw -4
        send(32'h43F0D093, 64'h104, 64'h8000_0000_0000_0000, 64'd0,
             mk(64'h8000_0000_0000_0000, 64'd63, 4'b1101, 64'd0, 3'd0, 1'b0, 64'h104));
        send(32'h4400D093, 64'h108, 64'd9, 64'd9, mk(64'd0, 64'd0, 4'b0000, 64'd0, 3'd7, 1'b0, 64'h108));
        send(32'h0020D063, 64'h10C, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
             mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'b0111, 64'd0, 3'd3, 1'b1, 64'h10C));
        send(32'h00209063, 64'h110, 64'd3, 64'd4, mk(64'd3, 64'd4, 4'b0110, 64'd0, 3'd3, 1'b1, 64'h110));
        send(32'hFE20AE23, 64'h114, 64'h1000, 64'hABCD,
             mk(64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 4'b0010, 64'hABCD, 3'd2, 1'b0, 64'h114));
        drain_all();

        // Stall: A in main, B in skid, C held off until release
        bus.out_ready = 1'b0;
        send(32'h002081B3, 64'h200, 64'd1, 64'd2, mk(64'd1, 64'd2, 4'b0010, 64'd0, 3'd0, 1'b0, 64'h200));
        send(32'h402081B3, 64'h204, 64'd10, 64'd3, mk(64'd10, 64'd3, 4'b0110, 64'd0, 3'd0, 1'b0, 64'h204));
        put(32'hFFF0F093, 64'h208, 64'd77, 64'd0);
        @(negedge clk);
        chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("stall_hold_A", bus.out_input1, 64'd1);
        idle_cycles(2);
        @(negedge clk);
        chk("stall_in_ready_2", {63'd0, bus.in_ready}, 64'd0);
        chk("stall_hold_A_2", bus.out_pc, 64'h200);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_acc(mk(64'd77, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 64'd0, 3'd0, 1'b0, 64'h208));
        drain_all();

        // Flush with skid full and a new entry offered in the flush cycle
        bus.out_ready = 1'b0;
        send(32'h0020E1B3, 64'h300, 64'd1, 64'd2, mk(64'd1, 64'd2, 4'b0001, 64'd0, 3'd0, 1'b0, 64'h300));
        send(32'h0000B083, 64'h304, 64'h40, 64'd0, mk(64'h40, 64'd0, 4'b0010, 64'd0, 3'd1, 1'b0, 64'h304));
        @(negedge clk);
        chk("pre_flush_in_ready", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b1;
        put(32'h002081B3, 64'h3FC, 64'd11, 64'd22);
        @(posedge clk); #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("flush_in_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.out_ready = 1'b1;
        idle_cycles(5);

        // lui with negative upper immediate, unknown opcode
        send(32'h800000B7, 64'h400, 64'd123, 64'd0,
             mk(64'd0, 64'hFFFF_FFFF_8000_0000, 4'b0010, 64'd0, 3'd4, 1'b0, 64'h400));
        send(32'h0000807F, 64'h404, 64'd5, 64'd6, mk(64'd0, 64'd0, 4'b0000, 64'd0, 3'd7, 1'b0, 64'h404));
        drain_all();

        // Asynchronous reset while stalled with both entries held
        bus.out_ready = 1'b0;
        send(32'h002081B3, 64'h500, 64'd8, 64'd9, mk(64'd8, 64'd9, 4'b0010, 64'd0, 3'd0, 1'b0, 64'h500));
        send(32'h402081B3, 64'h504, 64'd8, 64'd9, mk(64'd8, 64'd9, 4'b0110, 64'd0, 3'd0, 1'b0, 64'h504));
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("async_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("async_rst_input1", bus.out_input1, 64'd0);
        chk("async_rst_pc", bus.out_pc, 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        idle_cycles(4);
        @(negedge clk);
        chk("post_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
